e_md_sched: RTL and testbench

//  E-stage multiply/divide scheduler. Accepts one mult/multu/div/divu/mthi/mtlo per start

---
 rtl/e_md_sched_pkg.sv | 36 +++
 rtl/e_md_sched_arith.sv | 67 ++++++
 rtl/e_md_sched.sv | 114 +++++++++++
 tb/tb_e_md_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/e_md_sched_pkg.sv
//------------------------------------------------------------------------------
// Module : e_md_sched_pkg
// Brief  : Shared opcode, state and latency definitions for the E-stage md scheduler.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package e_md_sched_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Reserved encoding behaves exactly like "no operation".
    function automatic logic md_is_valid(input md_op_e op);
        return (op != MD_NONE) && (op != MD_RSVD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_md_sched_arith.sv
//------------------------------------------------------------------------------
// Module : e_md_sched_arith
// Brief  : Combinational HI/LO result and write-enable for a latched md operation.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module e_md_sched_arith
    import e_md_sched_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic               w_div_zero;
    logic               w_div_ovf;

    assign w_sa       = a_i;
    assign w_sb       = b_i;
    assign w_sprod    = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign w_uprod    = {32'd0, a_i} * {32'd0, b_i};
    assign w_div_zero = (b_i == 32'd0);
    assign w_div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign w_squo     = w_div_zero ? 32'sd0 : (w_sa / w_sb);
    assign w_srem     = w_div_zero ? 32'sd0 : (w_sa % w_sb);

    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        wr_o = 1'b0;
        case (op_i)
            MD_MULT: begin
                {hi_o, lo_o} = w_sprod;
                wr_o         = 1'b1;
            end
            MD_MULTU: begin
                {hi_o, lo_o} = w_uprod;
                wr_o         = 1'b1;
            end
            MD_DIV: begin
                // Most-negative / -1 overflows the quotient; define it as wrap with zero remainder.
                hi_o = w_div_ovf ? 32'd0 : w_srem;
                lo_o = w_div_ovf ? 32'h8000_0000 : w_squo;
                wr_o = ~w_div_zero;
            end
            MD_DIVU: begin
                hi_o = w_div_zero ? 32'd0 : (a_i % b_i);
                lo_o = w_div_zero ? 32'd0 : (a_i / b_i);
                wr_o = ~w_div_zero;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_md_sched.sv
//------------------------------------------------------------------------------
// Module : e_md_sched
// Brief  : E-stage multiply/divide scheduler owning the shared HI/LO registers.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module e_md_sched
    import e_md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e          state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    md_op_e             op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    md_op_e             w_op;
    logic               w_accept;
    logic [31:0]        w_hi_d;
    logic [31:0]        w_lo_d;
    logic               w_wr;

    assign w_op     = md_op_e'(mdOp);
    assign w_accept = start & ~req & (state_q == S_IDLE) & md_is_valid(w_op);

    e_md_sched_arith u_arith (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_o (w_hi_d),
        .lo_o (w_lo_d),
        .wr_o (w_wr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                state_q <= S_BUSY;
                                busy_q  <= 1'b1;
                                cnt_q   <= (w_op == MD_DIV || w_op == MD_DIVU) ? DIV_LOAD : MULT_LOAD;
                                op_q    <= w_op;
                                a_q     <= srcA;
                                b_q     <= srcB;
                            end
                            MD_MTHI: hi_q <= srcA;
                            MD_MTLO: lo_q <= srcA;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // req is ignored here: the in-flight op belongs to an older, committed instruction.
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (w_wr) begin
                            hi_q <= w_hi_d;
                            lo_q <= w_lo_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_e_md_sched.sv
//------------------------------------------------------------------------------
// Module : tb_e_md_sched
// Brief  : Directed vector bench for the E-stage md scheduler.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_e_md_sched;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    e_md_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .mdOp    (mdOp),
        .srcA    (srcA),
        .srcB    (srcB),
        .req     (req),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble operands after accept, and check busy for every cycle.
    task automatic run_op(input int idx, input vec_t v);
        start = 1'b1;
        mdOp  = v.op;
        srcA  = v.a;
        srcB  = v.b;
        tick();
        start = 1'b0;
        mdOp  = 3'b000;
        srcA  = $urandom;
        srcB  = $urandom;
        for (int c = 0; c < v.lat; c++) begin
            chk($sformatf("v%0d busy c%0d", idx, c + 1), {31'd0, busy}, 32'd1);
            tick();
        end
        chk($sformatf("v%0d busy done", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d hi", idx), hi, v.hi);
        chk($sformatf("v%0d lo", idx), lo, v.lo);
    endtask

    initial begin
        vecs[0]  = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0004, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF4};
        vecs[1]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{3'b100, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[3]  = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{3'b011, 32'h0000_0005, 32'h0000_0000, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{3'b101, 32'h0000_1234, 32'h0000_0000, 0,  32'h0000_1234, 32'h8000_0000};
        vecs[7]  = '{3'b110, 32'h0000_0007, 32'h0000_0000, 0,  32'h0000_1234, 32'h0000_0007};
        vecs[8]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{3'b001, 32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
        vecs[11] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_000A, 10, 32'h0000_0005, 32'h1999_9999};
        vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001};
        vecs[13] = '{3'b111, 32'h0000_0055, 32'h0000_0003, 0,  32'h0000_0000, 32'h0000_0001};
        vecs[14] = '{3'b100, 32'h0000_0009, 32'h0000_0000, 10, 32'h0000_0000, 32'h0000_0001};

        reset_n = 1'b0;
        start   = 1'b0;
        mdOp    = 3'b000;
        srcA    = 32'd0;
        srcB    = 32'd0;
        req     = 1'b0;
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_op(i, vecs[i]);
        end

        // req in the same cycle as start cancels the accept.
        start = 1'b1;
        mdOp  = 3'b001;
        srcA  = 32'h0000_0003;
        srcB  = 32'h0000_0003;
        req   = 1'b1;
        tick();
        start = 1'b0;
        req   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("req cancel busy c%0d", c), {31'd0, busy}, 32'd0);
            tick();
        end
        chk("req cancel hi", hi, 32'd0);
        chk("req cancel lo", lo, 32'd1);

        // req and operand changes mid-flight must not disturb a div: 100/7 -> q=14 r=2.
        start = 1'b1;
        mdOp  = 3'b011;
        srcA  = 32'd100;
        srcB  = 32'd7;
        tick();
        start = 1'b0;
        mdOp  = 3'b000;
        for (int c = 1; c <= 10; c++) begin
            req  = (c == 3);
            srcA = 32'd999 + c;
            chk($sformatf("req mid busy c%0d", c), {31'd0, busy}, 32'd1);
            tick();
        end
        req = 1'b0;
        chk("req mid busy done", {31'd0, busy}, 32'd0);
        chk("req mid hi", hi, 32'd2);
        chk("req mid lo", lo, 32'd14);

        // Asynchronous reset in the 4th busy cycle of a div aborts without commit.
        start = 1'b1;
        mdOp  = 3'b011;
        srcA  = 32'd50;
        srcB  = 32'd5;
        tick();
        start = 1'b0;
        mdOp  = 3'b000;
        tick();
        tick();
        tick();
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset hi", hi, 32'd0);
        chk("async reset lo", lo, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("post-reset idle c%0d", c), {31'd0, busy}, 32'd0);
            tick();
        end
        chk("post-reset hi", hi, 32'd0);
        chk("post-reset lo", lo, 32'd0);

        run_op(100, '{3'b110, 32'h0000_0007, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0007});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hazard unit contract: no md start may be presented while busy.
    always @(posedge clk) begin
        if (reset_n && busy && start) begin
            assert (!(mdOp != 3'b000 && mdOp != 3'b111))
                else $error("start presented while busy");
        end
    end

endmodule

`default_nettype wire
